// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions and exception codes.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int IP_LSB        = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_BD_BIT  = 31;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/irq_line.sv
// One hardware interrupt line: input synchroniser, optional rising-edge
// detector and a software-clearable pending flop for edge mode.
module irq_line #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_async,
  input  logic clr,
  output logic pend
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   synced;

  // Shift the asynchronous line through the synchroniser chain.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = irq_async;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchroniser register; flushed by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_MODE) begin : g_edge
      logic prev_q, prev_d;
      logic pend_q, pend_d;

      // Pending bit: a rising edge sets it, a W1C clears it, set wins.
      always_comb begin
        prev_d = synced;
        pend_d = pend_q;
        if (clr)              pend_d = 1'b0;
        if (synced & ~prev_q) pend_d = 1'b1;
      end

      // Edge detector history and pending state.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          prev_q <= 1'b0;
          pend_q <= 1'b0;
        end else begin
          prev_q <= prev_d;
          pend_q <= pend_d;
        end
      end

      assign pend = pend_q;
    end else begin : g_level
      logic unused_clr;
      assign unused_clr = clr;
      assign pend       = synced;
    end
  endgenerate

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor 0 with interrupt controller: SR, Cause, EPC, PRId, precise
// exception/interrupt entry at MEM and EXL clear on ERET in WB.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ     = 6,
  parameter logic [5:0]  EDGE_MASK   = 6'b000000,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] PRID        = 32'h0000_2019
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [4:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [31:0]        pc_m,
  input  logic               bd_m,
  input  logic [4:0]         exc_code_m,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               eret_w,
  output logic               int_req,
  output logic [31:0]        epc,
  output logic               exl
);

  logic [NUM_IRQ-1:0] sr_im_q, sr_im_d;
  logic               sr_exl_q, sr_exl_d;
  logic               sr_ie_q, sr_ie_d;
  logic               cause_bd_q, cause_bd_d;
  logic [4:0]         cause_exc_q, cause_exc_d;
  logic [31:0]        epc_q, epc_d;

  logic [NUM_IRQ-1:0] ip;
  logic [NUM_IRQ-1:0] ip_clr;
  logic               irq_pend;
  logic               exc_pend;
  logic               mtc0_ok;
  logic [31:0]        sr_val;
  logic [31:0]        cause_val;

  assign mtc0_ok = we & ~int_req;

  generate
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
      assign ip_clr[i] = mtc0_ok & (addr == REG_CAUSE) & wdata[IP_LSB + i];
      irq_line #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MASK[i])
      ) u_line (
        .clk       (clk),
        .reset     (reset),
        .irq_async (irq[i]),
        .clr       (ip_clr[i]),
        .pend      (ip[i])
      );
    end
  endgenerate

  // Take requests: exceptions and enabled interrupts, both blocked by EXL.
  always_comb begin
    irq_pend = (|(ip & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    exc_pend = (|exc_code_m) & ~sr_exl_q;
    int_req  = exc_pend | irq_pend;
  end

  // Register updates: entry beats MTC0; ERET clears EXL after any SR write.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (int_req) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = bd_m;
      cause_exc_d = exc_pend ? exc_code_m : EXC_INT;
      epc_d       = (bd_m ? pc_m - 32'd4 : pc_m) & ~32'd3;
    end else if (we) begin
      case (addr)
        REG_SR: begin
          sr_im_d  = wdata[IP_LSB +: NUM_IRQ];
          sr_exl_d = wdata[SR_EXL_BIT];
          sr_ie_d  = wdata[SR_IE_BIT];
        end
        REG_EPC: epc_d = {wdata[31:2], 2'b00};
        default: ;
      endcase
    end
    if (eret_w) sr_exl_d = 1'b0;
  end

  // CP0 state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  // MFC0 read mux; unimplemented bits and registers read as zero.
  always_comb begin
    sr_val                               = '0;
    sr_val[IP_LSB +: NUM_IRQ]            = sr_im_q;
    sr_val[SR_EXL_BIT]                   = sr_exl_q;
    sr_val[SR_IE_BIT]                    = sr_ie_q;
    cause_val                            = '0;
    cause_val[CAUSE_BD_BIT]              = cause_bd_q;
    cause_val[IP_LSB +: NUM_IRQ]         = ip;
    cause_val[CAUSE_EXC_LSB +: 5]        = cause_exc_q;
    case (addr)
      REG_SR:    rdata = sr_val;
      REG_CAUSE: rdata = cause_val;
      REG_EPC:   rdata = epc_q;
      REG_PRID:  rdata = PRID;
      default:   rdata = '0;
    endcase
  end

  assign epc = epc_q;
  assign exl = sr_exl_q;

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: six lines, line 1 edge-triggered, 2-stage sync.
module tb_cp0_intc;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic [5:0]  irq;
  logic        eret_w;
  logic        int_req;
  logic [31:0] epc;
  logic        exl;

  int total;
  int bad;

  cp0_intc #(
    .NUM_IRQ     (6),
    .EDGE_MASK   (6'b000010),
    .SYNC_STAGES (2),
    .PRID        (32'h0000_2019)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exc_code_m (exc_code_m),
    .irq        (irq),
    .eret_w     (eret_w),
    .int_req    (int_req),
    .epc        (epc),
    .exl        (exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then leave a gap before touching inputs.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Read a CP0 register combinationally and compare.
  task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  // MTC0 over one clock edge.
  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
    we = 1'b0; wdata = '0;
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; pc_m = '0; bd_m = 1'b0;
    exc_code_m = '0; irq = '0; eret_w = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;

    // Reset state
    read_check("rst_sr", 5'd12, 32'h0);
    read_check("rst_cause", 5'd13, 32'h0);
    read_check("rst_epc", 5'd14, 32'h0);
    read_check("rst_prid", 5'd15, 32'h0000_2019);
    read_check("rd_other", 5'd16, 32'h0);
    check("rst_exl", 32'(exl), 32'h0);
    check("rst_int_req", 32'(int_req), 32'h0);

    // Level interrupt on line 0
    mtc0(5'd12, 32'h0000_0401);
    read_check("sr_written", 5'd12, 32'h0000_0401);
    pc_m = 32'h0000_1000;
    irq[0] = 1'b1;
    step();
    read_check("lvl_ip_sync1", 5'd13, 32'h0);
    check("lvl_noreq_sync1", 32'(int_req), 32'h0);
    step();
    read_check("lvl_ip_set", 5'd13, 32'h0000_0400);
    check("lvl_req", 32'(int_req), 32'h1);
    step();
    check("lvl_epc", epc, 32'h0000_1000);
    check("lvl_exl", 32'(exl), 32'h1);
    read_check("lvl_cause", 5'd13, 32'h0000_0400);
    read_check("lvl_sr_exl", 5'd12, 32'h0000_0403);
    check("lvl_blocked", 32'(int_req), 32'h0);
    irq[0] = 1'b0;
    step(); step();
    read_check("lvl_ip_clear", 5'd13, 32'h0);
    eret_w = 1'b1;
    step();
    eret_w = 1'b0;
    #1;
    check("lvl_eret_exl", 32'(exl), 32'h0);
    check("lvl_eret_noreq", 32'(int_req), 32'h0);

    // Synchronous exception in a delay slot with IE off
    mtc0(5'd12, 32'h0);
    exc_code_m = 5'd12; bd_m = 1'b1; pc_m = 32'h0000_3008;
    #1;
    check("exc_req", 32'(int_req), 32'h1);
    step();
    exc_code_m = '0; bd_m = 1'b0;
    #1;
    check("exc_epc", epc, 32'h0000_3004);
    check("exc_exl", 32'(exl), 32'h1);
    read_check("exc_cause", 5'd13, 32'h8000_0030);
    eret_w = 1'b1;
    step();
    eret_w = 1'b0;
    #1;
    check("exc_eret_exl", 32'(exl), 32'h0);

    // MTC0 EPC clears the low two bits
    mtc0(5'd14, 32'h1234_5677);
    read_check("epc_write", 5'd14, 32'h1234_5674);

    // Edge line 1, masked: pulse latches until W1C
    irq[1] = 1'b1;
    step();
    irq[1] = 1'b0;
    step();
    read_check("edge_not_yet", 5'd13, 32'h8000_0030);
    step();
    read_check("edge_latched", 5'd13, 32'h8000_0830);
    step(); step();
    read_check("edge_held", 5'd13, 32'h8000_0830);
    check("edge_masked_noreq", 32'(int_req), 32'h0);
    mtc0(5'd13, 32'h0000_0800);
    read_check("edge_w1c", 5'd13, 32'h8000_0030);

    // Exception and enabled interrupt together, plus an ignored SR write
    mtc0(5'd12, 32'h0000_0401);
    irq[0] = 1'b1;
    step(); step();
    #1;
    check("both_irq_req", 32'(int_req), 32'h1);
    exc_code_m = 5'd10; pc_m = 32'h0000_4000;
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC00;
    step();
    we = 1'b0; wdata = '0; exc_code_m = '0;
    read_check("both_cause", 5'd13, 32'h0000_0428);
    read_check("both_sr_kept", 5'd12, 32'h0000_0403);
    check("both_epc", epc, 32'h0000_4000);

    // EXL blocks the still-pending interrupt until ERET
    step();
    #1;
    check("exl_blocks", 32'(int_req), 32'h0);
    eret_w = 1'b1;
    #1;
    check("exl_blocks_eret_cycle", 32'(int_req), 32'h0);
    step();
    eret_w = 1'b0;
    #1;
    check("after_eret_req", 32'(int_req), 32'h1);

    // Reset in the middle of a handler
    step();
    reset = 1'b1;
    #1;
    check("midrst_exl", 32'(exl), 32'h0);
    check("midrst_epc", epc, 32'h0);
    irq[0] = 1'b0;
    step();
    reset = 1'b0;
    read_check("midrst_cause", 5'd13, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
